sg_wave_sequencer: RTL and testbench

//  Table-driven command sequencer for the signal generator control port. Holds up to N_ENTRY

---
 rtl/sg_seq_pkg.sv | 41 ++++
 rtl/sg_wave_sequencer_if.sv | 16 +
 rtl/sg_seq_table.sv | 33 +++
 rtl/sg_wave_sequencer.sv | 169 ++++++++++++++++
 tb/tb_sg_wave_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sg_seq_pkg.sv
// Shared definitions for the waveform sequencer.
//  - default table depth, descriptor width and loop-count width
//  - descriptor field layout as a packed struct (bit 0 = freq LSB)
//  - sequencer FSM state encoding
package sg_seq_pkg;

    localparam int unsigned N_ENTRY_DEF = 16;
    localparam int unsigned DW_DEF      = 128;
    localparam int unsigned LW_DEF      = 16;

    localparam int unsigned FREQ_LSB    = 0;
    localparam int unsigned PHASE_LSB   = 32;
    localparam int unsigned ADDR_LSB    = 64;
    localparam int unsigned GAIN_LSB    = 80;
    localparam int unsigned NSAMP_LSB   = 96;
    localparam int unsigned OUTSEL_LSB  = 112;
    localparam int unsigned MODE_BIT    = 114;
    localparam int unsigned STDYSEL_BIT = 115;
    localparam int unsigned PHRST_BIT   = 116;

    // Declared MSB first so the packed layout matches the bit offsets above.
    typedef struct packed {
        logic [10:0] rsvd;     // [127:117], always zero
        logic        phrst;    // [116]
        logic        stdysel;  // [115]
        logic        mode;     // [114]
        logic [1:0]  outsel;   // [113:112]
        logic [15:0] nsamp;    // [111:96]
        logic [15:0] gain;     // [95:80]
        logic [15:0] addr;     // [79:64]
        logic [31:0] phase;    // [63:32]
        logic [31:0] freq;     // [31:0]
    } desc_t;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StSend
    } state_t;

endpackage

// File: rtl/sg_wave_sequencer_if.sv
// AXI-Stream command channel from the sequencer to the signal generator.
//  tvalid : descriptor valid (master -> slave)
//  tready : generator accepts (slave -> master)
//  tdata  : packed descriptor (master -> slave)
interface sg_wave_sequencer_if #(
    parameter int unsigned DW = 128
) ();

    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/sg_seq_table.sv
// Descriptor table: N_ENTRY x DW simple dual-port RAM.
//  clk     : clock
//  wr_en   : write strobe;  wr_addr / wr_data : write port
//  rd_en   : read strobe;   rd_addr : read address
//  rd_data : registered read data, valid the cycle after rd_en
// A read and a write to the same address in one cycle return the old contents.
// The array is deliberately not reset so the table survives a sequencer reset.
module sg_seq_table #(
    parameter int unsigned N_ENTRY = 16,
    parameter int unsigned DW      = 128,
    parameter int unsigned AW      = $clog2(N_ENTRY)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [N_ENTRY];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sg_wave_sequencer.sv
// Table-driven command sequencer in front of the signal generator command port.
// Plays table entries first..last (wrapping modulo N_ENTRY) on an AXIS master,
// nloop passes or forever when nloop == 0, until a stop pulse aborts it.
//  aclk, areset       : clock, asynchronous active-high reset
//  wr_en/addr/data    : table write port (allowed while busy)
//  start, stop        : 1-cycle control pulses
//  first, last, nloop : sequence bounds, latched on an accepted start
//  busy, done, cur_idx: status (done only on natural completion)
//  m_axis             : descriptor stream to the generator
module sg_wave_sequencer
    import sg_seq_pkg::*;
#(
    parameter int unsigned N_ENTRY = N_ENTRY_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned LW      = LW_DEF,
    localparam int unsigned AW     = $clog2(N_ENTRY)
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 start,
    input  logic                 stop,
    input  logic [AW-1:0]        first,
    input  logic [AW-1:0]        last,
    input  logic [LW-1:0]        nloop,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        cur_idx,
    sg_wave_sequencer_if.master  m_axis
);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] first_q, first_d;
    logic [AW-1:0] last_q, last_d;
    logic [LW-1:0] nloop_q, nloop_d;
    logic [LW-1:0] loop_q, loop_d;
    logic          stop_pend_q, stop_pend_d;
    logic          done_q, done_d;
    logic          tvalid_q, tvalid_d;
    logic [DW-1:0] tdata_q, tdata_d;

    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          hs;

    sg_seq_table #(
        .N_ENTRY (N_ENTRY),
        .DW      (DW),
        .AW      (AW)
    ) u_table (
        .clk     (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign hs = tvalid_q & m_axis.tready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        first_d     = first_q;
        last_d      = last_q;
        nloop_d     = nloop_q;
        loop_d      = loop_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        rd_en       = 1'b0;
        rd_addr     = ptr_q;

        case (state_q)
            StIdle: begin
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    first_d = first;
                    last_d  = last;
                    nloop_d = nloop;
                    ptr_d   = first;
                    loop_d  = LW'(1);
                    rd_en   = 1'b1;
                    rd_addr = first;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (stop) begin
                    state_d = StIdle;
                end else begin
                    tdata_d  = rd_data;
                    tvalid_d = 1'b1;
                    state_d  = StSend;
                end
            end
            StSend: begin
                // A stop during a stalled beat is remembered until the handshake.
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (hs) begin
                    tvalid_d = 1'b0;
                    if (stop || stop_pend_q) begin
                        stop_pend_d = 1'b0;
                        state_d     = StIdle;
                    end else if (ptr_q != last_q) begin
                        ptr_d   = ptr_q + AW'(1);
                        rd_en   = 1'b1;
                        rd_addr = ptr_q + AW'(1);
                        state_d = StFetch;
                    end else if (nloop_q == '0 || loop_q < nloop_q) begin
                        // nloop == 0 is an endless run: the pass counter stays put
                        if (nloop_q != '0) begin
                            loop_d = loop_q + LW'(1);
                        end
                        ptr_d   = first_q;
                        rd_en   = 1'b1;
                        rd_addr = first_q;
                        state_d = StFetch;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            first_q     <= '0;
            last_q      <= '0;
            nloop_q     <= '0;
            loop_q      <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            first_q     <= first_d;
            last_q      <= last_d;
            nloop_q     <= nloop_d;
            loop_q      <= loop_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign cur_idx       = ptr_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;

endmodule

// File: tb/tb_sg_wave_sequencer.sv
// Self-checking bench for sg_wave_sequencer: expected descriptors are pushed
// to a queue as each sequence is launched and popped at every handshake.
module tb_sg_wave_sequencer;
    import sg_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [3:0]   wr_addr = '0;
    logic [127:0] wr_data = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [3:0]   first = '0;
    logic [3:0]   last = '0;
    logic [15:0]  nloop = '0;
    logic         busy;
    logic         done;
    logic [3:0]   cur_idx;

    int unsigned  ready_mode = 0;   // 0: always ready, 1: low 3 of 5, 2: manual
    logic         man_ready = 1'b0;
    int unsigned  pat_cyc = 0;

    int unsigned  checks = 0;
    int unsigned  passes = 0;
    int unsigned  mon_checks = 0;
    int unsigned  mon_passes = 0;
    int unsigned  done_cnt = 0;

    logic [127:0] exp_q [$];
    logic [127:0] model [16];

    sg_wave_sequencer_if #(.DW(128)) axis ();

    assign axis.tready = (ready_mode == 0) ? 1'b1 :
                         (ready_mode == 1) ? ((pat_cyc % 5) < 2) : man_ready;

    sg_wave_sequencer dut (
        .aclk    (clk),
        .areset  (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .stop    (stop),
        .first   (first),
        .last    (last),
        .nloop   (nloop),
        .busy    (busy),
        .done    (done),
        .cur_idx (cur_idx),
        .m_axis  (axis)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pat_cyc <= pat_cyc + 1;

    // Scoreboard / protocol monitor, sampled on the falling edge.
    initial begin
        logic         stall;
        logic [127:0] stall_data;
        logic [127:0] e;
        stall = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    mon_checks++;
                    if (axis.tvalid !== 1'b1 || axis.tdata !== stall_data)
                        $display("FAIL stall_hold: tvalid=%b tdata=%h required tvalid=1 tdata=%h",
                                 axis.tvalid, axis.tdata, stall_data);
                    else mon_passes++;
                end
                if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
                    mon_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_beat: got tdata=%h required no beat", axis.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (axis.tdata !== e)
                            $display("FAIL beat_data: got %h required %h", axis.tdata, e);
                        else mon_passes++;
                    end
                end
                if (done === 1'b1) done_cnt++;
                stall = (axis.tvalid === 1'b1) && (axis.tready === 1'b0);
                stall_data = axis.tdata;
            end
        end
    end

    function automatic logic [127:0] mk_desc(input int unsigned f, input int unsigned idx);
        desc_t d;
        d = '0;
        d.freq    = f;
        d.phase   = 32'hA000_0000 + idx;
        d.addr    = 16'(idx * 3);
        d.gain    = 16'(16'h0100 + idx);
        d.nsamp   = 16'(idx + 8);
        d.outsel  = 2'(idx);
        d.mode    = idx[0];
        d.stdysel = idx[1];
        d.phrst   = 1'b1;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int unsigned a, input logic [127:0] d);
        wr_addr = 4'(a);
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        model[a] = d;
    endtask

    task automatic do_start(input int unsigned f, input int unsigned l, input int unsigned n);
        first = 4'(f);
        last  = 4'(l);
        nloop = 16'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (axis.tvalid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (axis.tvalid !== 1'b0 || axis.tdata !== '0)
            $display("FAIL reset_axis: tvalid=%b tdata=%h required 0/0", axis.tvalid, axis.tdata);
        else passes++;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cur_idx !== 4'd0)
            $display("FAIL reset_status: busy=%b done=%b cur_idx=%0d required 0/0/0",
                     busy, done, cur_idx);
        else passes++;
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || axis.tvalid !== 1'b0)
            $display("FAIL reset_release: busy=%b tvalid=%b required 0/0", busy, axis.tvalid);
        else passes++;
    endtask

    task automatic test_basic();
        bit ok;
        int unsigned d0;
        for (int i = 0; i < 4; i++) write_entry(i, mk_desc(100 + i, i));
        ready_mode = 0;
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(model[i]);
        do_start(0, 3, 1);
        checks++;
        if (busy !== 1'b1 || axis.tvalid !== 1'b0)
            $display("FAIL basic_latency1: busy=%b tvalid=%b required 1/0", busy, axis.tvalid);
        else passes++;
        tick();
        checks++;
        if (axis.tvalid !== 1'b1 || cur_idx !== 4'd0)
            $display("FAIL basic_latency2: tvalid=%b cur_idx=%0d required 1/0",
                     axis.tvalid, cur_idx);
        else passes++;
        wait_idle(ok);
        checks++;
        if (!ok || exp_q.size() != 0)
            $display("FAIL basic_complete: idle=%0d left=%0d required 1/0", ok, exp_q.size());
        else passes++;
        tick();
        checks++;
        if (done_cnt !== d0 + 1)
            $display("FAIL basic_done: pulses=%0d required %0d", done_cnt - d0, 1);
        else passes++;
    endtask

    task automatic test_stall();
        bit ok;
        int unsigned d0;
        ready_mode = 1;
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(model[i]);
        do_start(0, 3, 1);
        wait_idle(ok);
        tick();
        checks++;
        if (!ok || exp_q.size() != 0 || done_cnt !== d0 + 1)
            $display("FAIL stall_seq: idle=%0d left=%0d done=%0d required 1/0/1",
                     ok, exp_q.size(), done_cnt - d0);
        else passes++;
    endtask

    task automatic test_wrap();
        bit ok;
        int unsigned d0;
        int unsigned seq [4] = '{14, 15, 0, 1};
        write_entry(14, mk_desc(114, 14));
        write_entry(15, mk_desc(115, 15));
        ready_mode = 1;
        d0 = done_cnt;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++) exp_q.push_back(model[seq[i]]);
        do_start(14, 1, 2);
        wait_idle(ok);
        tick();
        checks++;
        if (!ok || exp_q.size() != 0)
            $display("FAIL wrap_seq: idle=%0d left=%0d required 1/0", ok, exp_q.size());
        else passes++;
        checks++;
        if (done_cnt !== d0 + 1)
            $display("FAIL wrap_done: pulses=%0d required 1", done_cnt - d0);
        else passes++;
    endtask

    task automatic test_stop();
        bit ok;
        int unsigned d0;
        ready_mode = 2;
        man_ready = 1'b0;
        d0 = done_cnt;
        for (int k = 0; k < 7; k++) exp_q.push_back(model[k % 4]);
        do_start(0, 3, 0);
        for (int k = 0; k < 7; k++) begin
            wait_valid(ok);
            checks++;
            if (!ok || cur_idx !== 4'(k % 4))
                $display("FAIL stop_beat_idx: valid=%0d cur_idx=%0d required 1/%0d",
                         ok, cur_idx, k % 4);
            else passes++;
            if (k == 6) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
            end
            man_ready = 1'b1;
            tick();
            man_ready = 1'b0;
        end
        checks++;
        if (busy !== 1'b0 || axis.tvalid !== 1'b0)
            $display("FAIL stop_abort: busy=%b tvalid=%b required 0/0", busy, axis.tvalid);
        else passes++;
        ready_mode = 0;
        repeat (8) tick();
        checks++;
        if (exp_q.size() != 0 || done_cnt !== d0 || busy !== 1'b0)
            $display("FAIL stop_after: left=%0d done=%0d busy=%b required 0/0/0",
                     exp_q.size(), done_cnt - d0, busy);
        else passes++;
    endtask

    task automatic test_misc();
        bit ok;
        int unsigned d0;
        // start while busy
        ready_mode = 0;
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(model[i]);
        do_start(0, 3, 1);
        repeat (2) tick();
        do_start(2, 2, 5);
        wait_idle(ok);
        tick();
        checks++;
        if (!ok || exp_q.size() != 0 || done_cnt !== d0 + 1)
            $display("FAIL start_busy: idle=%0d left=%0d done=%0d required 1/0/1",
                     ok, exp_q.size(), done_cnt - d0);
        else passes++;
        // start and stop together in idle
        stop = 1'b1;
        do_start(0, 3, 1);
        stop = 1'b0;
        repeat (6) tick();
        checks++;
        if (busy !== 1'b0 || axis.tvalid !== 1'b0)
            $display("FAIL start_stop_idle: busy=%b tvalid=%b required 0/0", busy, axis.tvalid);
        else passes++;
        // rewrite entry 2 while entry 1 is waiting in SEND
        ready_mode = 2;
        man_ready = 1'b0;
        d0 = done_cnt;
        exp_q.push_back(model[0]);
        exp_q.push_back(model[1]);
        exp_q.push_back(mk_desc(202, 2));
        exp_q.push_back(model[3]);
        do_start(0, 3, 1);
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok);
            checks++;
            if (!ok || cur_idx !== 4'(k))
                $display("FAIL rewrite_idx: valid=%0d cur_idx=%0d required 1/%0d", ok, cur_idx, k);
            else passes++;
            if (k == 1) write_entry(2, mk_desc(202, 2));
            man_ready = 1'b1;
            tick();
            man_ready = 1'b0;
        end
        wait_idle(ok);
        tick();
        checks++;
        if (!ok || exp_q.size() != 0 || done_cnt !== d0 + 1)
            $display("FAIL rewrite_seq: idle=%0d left=%0d done=%0d required 1/0/1",
                     ok, exp_q.size(), done_cnt - d0);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int unsigned d0;
        ready_mode = 2;
        man_ready = 1'b0;
        do_start(0, 3, 1);
        wait_valid(ok);
        checks++;
        if (!ok)
            $display("FAIL rst_mid_valid: tvalid=%b required 1", axis.tvalid);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if (axis.tvalid !== 1'b0 || busy !== 1'b0 || axis.tdata !== '0 || cur_idx !== 4'd0)
            $display("FAIL rst_mid_async: tvalid=%b busy=%b tdata=%h cur_idx=%0d required 0/0/0/0",
                     axis.tvalid, busy, axis.tdata, cur_idx);
        else passes++;
        tick();
        rst = 1'b0;
        tick();
        ready_mode = 0;
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(model[i]);
        do_start(0, 3, 1);
        wait_idle(ok);
        tick();
        checks++;
        if (!ok || exp_q.size() != 0 || done_cnt !== d0 + 1)
            $display("FAIL rst_replay: idle=%0d left=%0d done=%0d required 1/0/1",
                     ok, exp_q.size(), done_cnt - d0);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_stop();
        test_misc();
        test_reset_mid();
        repeat (2) tick();
        $display("%0d/%0d checks passed", passes + mon_passes, checks + mon_checks);
        $finish;
    end

endmodule
